// File: rtl/led_pattern_engine.sv
// Purpose: selectable LED pattern generator (8 patterns) with programmable step rate, PWM brightness and freeze.
// Latency: pattern register updates on the step edge (step_pulse high that cycle); led follows one cycle later.
// Backpressure: none; enable=0 holds pattern and prescaler, while mode changes and PWM keep running.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous reset, active-low
//   mode       - pattern select (off/walk/ping-pong/count/blink/fill/alternate/on)
//   tick_div   - clocks per pattern step, 0 behaves as 1
//   brightness - PWM duty select, 0 = off, all-ones = always on
//   enable     - 1 = advance pattern, 0 = freeze pattern and prescaler
//   led        - registered, PWM-gated LED drive
//   step_pulse - one-cycle pulse in the cycle the pattern register takes a step
module led_pattern_engine #(
  parameter int NUM_LEDS  = 8,
  parameter int DIV_WIDTH = 16,
  parameter int PWM_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           mode,
  input  logic [DIV_WIDTH-1:0] tick_div,
  input  logic [PWM_WIDTH-1:0] brightness,
  input  logic                 enable,
  output logic [NUM_LEDS-1:0]  led,
  output logic                 step_pulse
);

  typedef enum logic [2:0] {
    MODE_OFF   = 3'b000,
    MODE_WALK  = 3'b001,
    MODE_PING  = 3'b010,
    MODE_COUNT = 3'b011,
    MODE_BLINK = 3'b100,
    MODE_FILL  = 3'b101,
    MODE_ALT   = 3'b110,
    MODE_ON    = 3'b111
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [PWM_WIDTH-1:0] PWM_ONE = PWM_WIDTH'(1);
  localparam logic [NUM_LEDS-1:0]  PAT_ONE = NUM_LEDS'(1);

  // Even bit positions set: 0x55 for eight LEDs.
  function automatic logic [NUM_LEDS-1:0] alt_pattern();
    logic [NUM_LEDS-1:0] r;
    for (int i = 0; i < NUM_LEDS; i++) begin
      r[i] = ((i % 2) == 0);
    end
    return r;
  endfunction

  function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_e m);
    logic [NUM_LEDS-1:0] r;
    case (m)
      MODE_WALK, MODE_PING: r = PAT_ONE;
      MODE_ALT:             r = alt_pattern();
      MODE_ON:              r = '1;
      default:              r = '0;
    endcase
    return r;
  endfunction

  mode_e                mode_q, mode_d;
  dir_e                 dir_q, dir_d;
  logic [NUM_LEDS-1:0]  pattern_q, pattern_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [PWM_WIDTH-1:0] pwm_q, pwm_d;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic                 step_pulse_q, step_pulse_d;

  logic [DIV_WIDTH-1:0] eff_div;
  logic                 mode_chg;
  logic                 step;
  logic                 gate;
  logic [NUM_LEDS-1:0]  pat_next;
  dir_e                 dir_next;

  // Pattern successor for the stored mode.
  always_comb begin
    pat_next = pattern_q;
    dir_next = dir_q;
    case (mode_q)
      MODE_WALK:  pat_next = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
      MODE_PING: begin
        // Turn around at an end without repeating the end value.
        if (dir_q == DIR_UP) begin
          if (pattern_q[NUM_LEDS-1]) begin
            pat_next = pattern_q >> 1;
            dir_next = DIR_DOWN;
          end else begin
            pat_next = pattern_q << 1;
          end
        end else begin
          if (pattern_q[0]) begin
            pat_next = pattern_q << 1;
            dir_next = DIR_UP;
          end else begin
            pat_next = pattern_q >> 1;
          end
        end
      end
      MODE_COUNT: pat_next = pattern_q + PAT_ONE;
      MODE_BLINK: pat_next = ~pattern_q;
      MODE_FILL:  pat_next = (&pattern_q) ? '0 : {pattern_q[NUM_LEDS-2:0], 1'b1};
      MODE_ALT:   pat_next = ~pattern_q;
      default:    pat_next = pattern_q;
    endcase
  end

  always_comb begin
    pattern_d    = pattern_q;
    dir_d        = dir_q;
    presc_d      = presc_q;
    step_pulse_d = 1'b0;
    mode_d       = mode_e'(mode);

    eff_div  = (tick_div == '0) ? DIV_ONE : tick_div;
    mode_chg = (mode_e'(mode) != mode_q);
    // >= rather than == so a shrinking tick_div cannot strand the count past terminal.
    step     = enable && (presc_q >= (eff_div - DIV_ONE));

    if (mode_chg) begin
      pattern_d = init_pattern(mode_e'(mode));
      dir_d     = DIR_UP;
      presc_d   = '0;
    end else if (step) begin
      pattern_d    = pat_next;
      dir_d        = dir_next;
      presc_d      = '0;
      step_pulse_d = 1'b1;
    end else if (enable) begin
      presc_d = presc_q + DIV_ONE;
    end

    pwm_d = pwm_q + PWM_ONE;
    gate  = (brightness == '1) || (pwm_q < brightness);
    led_d = gate ? pattern_q : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= MODE_OFF;
      dir_q        <= DIR_UP;
      pattern_q    <= '0;
      presc_q      <= '0;
      pwm_q        <= '0;
      led_q        <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      pattern_q    <= pattern_d;
      presc_q      <= presc_d;
      pwm_q        <= pwm_d;
      led_q        <= led_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign led        = led_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Purpose: self-checking bench for led_pattern_engine against a step-index reference model.
// Latency: every clock edge is compared (led and step_pulse) one time unit after the edge.
// Backpressure: not applicable; the bench drives all inputs directly.
module tb_led_pattern_engine;

  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    mode;
  logic [15:0]   tick_div;
  logic [3:0]    brightness;
  logic          enable;
  logic [NL-1:0] led;
  logic          step_pulse;

  led_pattern_engine #(.NUM_LEDS(NL), .DIV_WIDTH(16), .PWM_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .tick_div   (tick_div),
    .brightness (brightness),
    .enable     (enable),
    .led        (led),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the pattern is a pure function of (mode it was loaded for, steps taken).
  int            m_mode;  // sampled mode copy
  int            pmode;   // mode whose pattern sits in the pattern register
  int            k;       // steps taken since that pattern was loaded
  int            c;       // prescaler count
  int            m_pwm;
  logic [NL-1:0] exp_led;
  logic          exp_pulse;

  function automatic logic [NL-1:0] pat(input int md, input int kk);
    logic [NL-1:0] alt;
    int pos, idx, j;
    for (int i = 0; i < NL; i++) alt[i] = ((i % 2) == 0);
    case (md)
      1: return NL'(1 << (kk % NL));
      2: begin
        pos = kk % (2 * NL - 2);
        idx = (pos < NL) ? pos : (2 * NL - 2 - pos);
        return NL'(1 << idx);
      end
      3: return NL'(kk % (1 << NL));
      4: return (kk % 2 == 1) ? {NL{1'b1}} : {NL{1'b0}};
      5: begin
        j = kk % (NL + 1);
        return NL'((1 << j) - 1);
      end
      6: return (kk % 2 == 1) ? ~alt : alt;
      7: return {NL{1'b1}};
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode    = 0;
    pmode     = 0;
    k         = 0;
    c         = 0;
    m_pwm     = 0;
    exp_led   = '0;
    exp_pulse = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model over one edge using the inputs presently driven, then compare.
  task automatic tick();
    int  eff;
    bit  gate;
    if (rst !== 1'b1) begin
      model_reset();
    end else begin
      gate    = (brightness == 4'hF) || (m_pwm < int'(brightness));
      exp_led = gate ? pat(pmode, k) : '0;
      m_pwm   = (m_pwm + 1) % 16;
      eff     = (tick_div == 0) ? 1 : int'(tick_div);
      if (int'(mode) != m_mode) begin
        m_mode    = int'(mode);
        pmode     = int'(mode);
        k         = 0;
        c         = 0;
        exp_pulse = 1'b0;
      end else if (enable && c >= eff - 1) begin
        k++;
        c         = 0;
        exp_pulse = 1'b1;
      end else begin
        if (enable) c++;
        exp_pulse = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("led", 32'(led), 32'(exp_led));
    chk("step_pulse", 32'(step_pulse), 32'(exp_pulse));
  endtask

  initial begin
    int            cnt;
    logic [NL-1:0] held;

    // Reset state
    rst = 1'b0; mode = 3'b000; tick_div = 16'd0; brightness = 4'd0; enable = 1'b0;
    model_reset();
    #1;
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_step", 32'(step_pulse), 32'h0);
    for (int i = 0; i < 5; i++) tick();

    // Walk at tick_div=4
    rst = 1'b1; mode = 3'b001; tick_div = 16'd4; brightness = 4'hF; enable = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (step_pulse === 1'b1) cnt++;
    end
    chk("walk_pulses_per_32", 32'(cnt), 32'd8);

    // Mode change from walk at led=0x10
    for (int i = 0; i < 64 && led !== 8'h10; i++) tick();
    chk("walk_reach_10", 32'(led), 32'h10);
    mode = 3'b110;
    tick();
    tick();
    chk("alt_load", 32'(led), 32'h55);
    for (int i = 0; i < 4; i++) tick();
    chk("alt_first_step", 32'(led), 32'hAA);

    // Freeze
    for (int i = 0; i < 2; i++) tick();
    enable = 1'b0;
    tick();
    held = led;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("freeze_hold", 32'(led), 32'(held));
    end
    enable = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // Ping-pong, then fill
    mode = 3'b010;
    for (int i = 0; i < 40; i++) tick();
    mode = 3'b101;
    for (int i = 0; i < 45; i++) tick();

    // Counter at tick_div=0: steps every cycle and wraps past 0xFF
    mode = 3'b011; tick_div = 16'd0;
    for (int i = 0; i < 280; i++) tick();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step_pulse === 1'b1) cnt++;
    end
    chk("count_pulses_per_20", 32'(cnt), 32'd20);

    // PWM
    mode = 3'b111; brightness = 4'd4;
    tick();
    tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (led === 8'hFF) cnt++;
    end
    chk("pwm_on_cycles", 32'(cnt), 32'd4);
    brightness = 4'd0;
    for (int i = 0; i < 20; i++) tick();
    chk("pwm_off", 32'(led), 32'h0);
    brightness = 4'hF;
    for (int i = 0; i < 20; i++) tick();
    chk("pwm_full", 32'(led), 32'hFF);

    // Async reset between edges
    mode = 3'b001; tick_div = 16'd3;
    for (int i = 0; i < 10; i++) tick();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_led", 32'(led), 32'h0);
    chk("async_step", 32'(step_pulse), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("release_no_pulse", 32'(step_pulse), 32'h0);
    tick();
    chk("release_led_01", 32'(led), 32'h01);
    for (int i = 0; i < 3; i++) tick();
    chk("release_led_02", 32'(led), 32'h02);

    // Randomized run against the model
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) tick_div = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) enable = ($urandom_range(0, 4) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
